// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare branch predictor: branch opcode/rt encodings,
// 2-bit counter encodings and the conditional-branch decoder.
package gshare_predictor_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [1:0] INIT_CTR_DEFAULT = CTR_WNT;

    typedef enum logic {StInit, StRun} state_t;

    function automatic logic is_cond_branch(input logic [31:0] instr);
        logic [5:0] op;
        logic [4:0] rt;
        logic       unused_fields;
        op            = instr[31:26];
        rt            = instr[20:16];
        unused_fields = ^{instr[25:21], instr[15:0]};
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: return 1'b1;
            OP_REGIMM: return (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                              (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_ctr2.sv
// 2-bit saturating up/down counter step, combinational; clamps at strongly taken/not-taken.
module gshare_predictor_sat_ctr2
    import gshare_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history direction predictor with speculative GHR, mispredict repair and
// a power-on sweep that initialises every pattern-history counter.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int unsigned GHR_W    = 12,
    parameter bit          GSHARE   = 1'b1,
    parameter logic [1:0]  INIT_CTR = INIT_CTR_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Lookup_valid,
    input  logic [31:0]      Instr_input,
    input  logic [31:0]      Instr_addr_input,
    output logic             Ready,
    output logic             Pred_valid,
    output logic             Taken,
    output logic [GHR_W-1:0] Pred_index,
    output logic [GHR_W-1:0] Pred_ghr,
    input  logic             Update_valid,
    input  logic [GHR_W-1:0] Update_index,
    input  logic [GHR_W-1:0] Update_ghr,
    input  logic             Update_taken,
    input  logic             Update_mispredict
);

    localparam int unsigned DEPTH = 2 ** GHR_W;

    state_t           state;
    logic [GHR_W-1:0] ptr;
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] idx;
    logic [1:0]       pht [DEPTH];

    logic             is_branch;
    logic             pred_dir;
    logic             mispredict;
    logic             accept;
    logic [1:0]       upd_ctr_next;
    logic             pht_we;
    logic [GHR_W-1:0] pht_waddr;
    logic [1:0]       pht_wdata;
    logic             unused_bits;

    assign unused_bits = ^{Instr_addr_input, Update_ghr[GHR_W-1]};

    assign idx        = GSHARE ? (Instr_addr_input[GHR_W+1:2] ^ ghr) : ghr;
    assign is_branch  = is_cond_branch(Instr_input);
    assign pred_dir   = is_branch & pht[idx][1];
    assign mispredict = Ready & Update_valid & Update_mispredict;
    // A lookup alongside a mispredict is on the wrong path and is dropped.
    assign accept     = Ready & Lookup_valid & ~mispredict;

    gshare_predictor_sat_ctr2 u_upd_ctr (
        .ctr  (pht[Update_index]),
        .inc  (Update_taken),
        .next (upd_ctr_next)
    );

    // The init sweep owns the single write port until the table is filled.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = Update_index;
        pht_wdata = upd_ctr_next;
        if (state == StInit) begin
            pht_we    = 1'b1;
            pht_waddr = ptr;
            pht_wdata = INIT_CTR;
        end else if (Ready && Update_valid && !RESET) begin
            pht_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (pht_we) pht[pht_waddr] <= pht_wdata;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= StInit;
            ptr        <= '0;
            ghr        <= '0;
            Ready      <= 1'b0;
            Pred_valid <= 1'b0;
            Taken      <= 1'b0;
            Pred_index <= '0;
            Pred_ghr   <= '0;
        end else begin
            Pred_valid <= accept;
            if (accept) begin
                Taken      <= pred_dir;
                Pred_index <= idx;
                Pred_ghr   <= ghr;
            end else begin
                Taken <= 1'b0;
            end
            unique case (state)
                StInit: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state <= StRun;
                        Ready <= 1'b1;
                    end
                end
                StRun: begin
                    // Repair takes priority over the speculative shift of a same-cycle lookup.
                    if (mispredict) begin
                        ghr <= {Update_ghr[GHR_W-2:0], Update_taken};
                    end else if (accept && is_branch) begin
                        ghr <= {ghr[GHR_W-2:0], pred_dir};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor (GHR_W=4): a reference model predicts every
// Pred_valid response; a negedge monitor pops and compares.
module tb_gshare_predictor;

    localparam int GW    = 4;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          Lookup_valid;
    logic [31:0]   Instr_input;
    logic [31:0]   Instr_addr_input;
    logic          Ready;
    logic          Pred_valid;
    logic          Taken;
    logic [GW-1:0] Pred_index;
    logic [GW-1:0] Pred_ghr;
    logic          Update_valid;
    logic [GW-1:0] Update_index;
    logic [GW-1:0] Update_ghr;
    logic          Update_taken;
    logic          Update_mispredict;

    always #5 CLK = ~CLK;

    gshare_predictor #(
        .GHR_W    (GW),
        .GSHARE   (1'b1),
        .INIT_CTR (2'b01)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Lookup_valid      (Lookup_valid),
        .Instr_input       (Instr_input),
        .Instr_addr_input  (Instr_addr_input),
        .Ready             (Ready),
        .Pred_valid        (Pred_valid),
        .Taken             (Taken),
        .Pred_index        (Pred_index),
        .Pred_ghr          (Pred_ghr),
        .Update_valid      (Update_valid),
        .Update_index      (Update_index),
        .Update_ghr        (Update_ghr),
        .Update_taken      (Update_taken),
        .Update_mispredict (Update_mispredict)
    );

    typedef struct packed {
        logic [GW-1:0] idx;
        logic [GW-1:0] ghr;
        logic          taken;
    } pred_t;

    pred_t exp_q[$];
    pred_t hist_q[$];
    int    errors = 0;
    int    checks = 0;

    int    m_ctr[DEPTH];
    int    m_ghr;
    bit    m_ready;

    localparam logic [31:0] BEQ = 32'h10220003;
    localparam logic [31:0] ADD = 32'h00221820;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_is_branch(input logic [31:0] instr);
        int op;
        int rt;
        op = int'(instr[31:26]);
        rt = int'(instr[20:16]);
        return (op >= 4 && op <= 7) ||
               (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17));
    endfunction

    function automatic logic [31:0] addr_for_idx(input int idx);
        return 32'h00400000 | (32'((idx ^ m_ghr) % DEPTH) << 2);
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_ghr   = 0;
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        hist_q.delete();
    endtask

    // Drive one cycle of stimulus and advance the reference model to match.
    task automatic step(input bit lv, input logic [31:0] instr, input logic [31:0] addr,
                        input bit uv, input int uidx, input int ughr, input bit ut,
                        input bit um);
        @(posedge CLK);
        #1;
        Lookup_valid      = lv;
        Instr_input       = instr;
        Instr_addr_input  = addr;
        Update_valid      = uv;
        Update_index      = GW'(uidx);
        Update_ghr        = GW'(ughr);
        Update_taken      = ut;
        Update_mispredict = um;
        if (m_ready) begin
            int    idx;
            bit    br;
            bit    tk;
            bit    mis;
            pred_t p;
            idx = (int'(addr >> 2) % DEPTH) ^ m_ghr;
            br  = ref_is_branch(instr);
            tk  = br && (m_ctr[idx] >= 2);
            mis = uv && um;
            if (lv && !mis) begin
                p.idx   = GW'(idx);
                p.ghr   = GW'(m_ghr);
                p.taken = tk;
                exp_q.push_back(p);
                if (br) hist_q.push_back(p);
            end
            if (uv) begin
                if (ut) m_ctr[uidx] = (m_ctr[uidx] == 3) ? 3 : m_ctr[uidx] + 1;
                else    m_ctr[uidx] = (m_ctr[uidx] == 0) ? 0 : m_ctr[uidx] - 1;
            end
            if (mis)              m_ghr = ((ughr * 2) + int'(ut)) % DEPTH;
            else if (lv && br)    m_ghr = ((m_ghr * 2) + int'(tk)) % DEPTH;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Ready must stay low for DEPTH cycles after reset release, then rise.
    task automatic check_sweep(input bit poke);
        check("ready_at_release", 32'(Ready), 32'd0);
        for (int k = 1; k < DEPTH; k++) begin
            @(posedge CLK);
            #1;
            if (poke) begin
                Lookup_valid      = 1'b1;
                Instr_input       = BEQ;
                Instr_addr_input  = 32'h00400010;
                Update_valid      = 1'b1;
                Update_index      = 4'd4;
                Update_ghr        = 4'b0010;
                Update_taken      = 1'b1;
                Update_mispredict = 1'b1;
            end
            check("ready_during_sweep", 32'(Ready), 32'd0);
        end
        @(posedge CLK);
        #1;
        Lookup_valid = 1'b0;
        Update_valid = 1'b0;
        check("ready_after_sweep", 32'(Ready), 32'd1);
        m_ready = 1'b1;
    endtask

    task automatic check_pht_init();
        for (int i = 0; i < DEPTH; i++) check("pht_init_value", 32'(dut.pht[i]), 32'd1);
    endtask

    always @(negedge CLK) begin
        if (!RESET && Pred_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pred_valid", 32'd1, 32'd0);
            end else begin
                pred_t e;
                e = exp_q.pop_front();
                check("pred_index", 32'(Pred_index), 32'(e.idx));
                check("pred_ghr", 32'(Pred_ghr), 32'(e.ghr));
                check("taken", 32'(Taken), 32'(e.taken));
            end
        end
    end

    initial begin
        RESET             = 1'b1;
        Lookup_valid      = 1'b0;
        Instr_input       = '0;
        Instr_addr_input  = '0;
        Update_valid      = 1'b0;
        Update_index      = '0;
        Update_ghr        = '0;
        Update_taken      = 1'b0;
        Update_mispredict = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_pred_valid", 32'(Pred_valid), 32'd0);
        check("reset_taken", 32'(Taken), 32'd0);
        check("reset_pred_index", 32'(Pred_index), 32'd0);
        check("reset_pred_ghr", 32'(Pred_ghr), 32'd0);
        RESET = 1'b0;
        // Lookups and updates poked during the sweep must be ignored.
        check_sweep(1'b1);
        check_pht_init();

        // BEQ at 0x00400010 with ghr=0: idx 4, not taken.
        step(1'b1, BEQ, 32'h00400010, 1'b0, 0, 0, 1'b0, 1'b0);
        // Two taken updates saturate toward 11, then predict taken.
        step(1'b0, 32'h0, 32'h0, 1'b1, 4, 0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 4, 0, 1'b1, 1'b0);
        step(1'b1, BEQ, 32'h00400010, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 4, 0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 4, 0, 1'b0, 1'b0);
        step(1'b1, BEQ, addr_for_idx(4), 1'b0, 0, 0, 1'b0, 1'b0);

        // Repair ghr to 0101, then a lookup racing a mispredict is dropped.
        step(1'b0, 32'h0, 32'h0, 1'b1, 0, 4'b0010, 1'b1, 1'b1);
        step(1'b1, BEQ, addr_for_idx(4), 1'b1, 1, 4'b0010, 1'b1, 1'b1);
        step(1'b1, ADD, addr_for_idx(4), 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 32'h04020000, addr_for_idx(4), 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 32'h04110000, addr_for_idx(4), 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, ADD, addr_for_idx(4), 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, BEQ, addr_for_idx(4), 1'b1, 4, 0, 1'b1, 1'b0);
        step(1'b1, BEQ, addr_for_idx(4), 1'b0, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            bit          lv;
            logic [31:0] instr;
            logic [31:0] addr;
            bit          uv;
            bit          ut;
            bit          um;
            int          uidx;
            int          ughr;
            pred_t       p;
            lv    = ($urandom_range(0, 3) != 0);
            instr = $urandom;
            addr  = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 7))
                0: instr[31:26] = 6'b000100;
                1: instr[31:26] = 6'b000101;
                2: instr[31:26] = 6'b000110;
                3: instr[31:26] = 6'b000111;
                4: begin
                    instr[31:26] = 6'b000001;
                    instr[20:16] = 5'($urandom_range(0, 3)) | (5'($urandom_range(0, 1)) << 4);
                end
                default: ;
            endcase
            uv = 1'b0; ut = 1'b0; um = 1'b0; uidx = 0; ughr = 0;
            if (hist_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                p    = hist_q.pop_front();
                uv   = 1'b1;
                ut   = 1'($urandom_range(0, 1));
                um   = (ut != p.taken);
                uidx = int'(p.idx);
                ughr = int'(p.ghr);
            end
            step(lv, instr, addr, uv, uidx, ughr, ut, um);
        end
        idle(3);

        // Reset mid-sweep at ptr=7 restarts the sweep from zero.
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        repeat (7) @(posedge CLK);
        #1;
        check("sweep_ptr_before_reset", 32'(dut.ptr), 32'd7);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_sweep(1'b0);
        check_pht_init();
        step(1'b1, BEQ, 32'h00400010, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, ADD, 32'h00400024, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
